// File: rtl/npu_ctrl_regs.sv
// AXI4-Lite control/status register slave for the NPU: CTRL, STATUS and byte-strobed general registers.
// Define NPU_CTRL_REGS_IRQ_EN to include the sticky DONE flag, the IRQ_EN bit and the irq_o logic.
module npu_ctrl_regs #(
    parameter int C_DATA_WIDTH = 32,
    parameter int C_NUM_REGS   = 16,
    parameter int C_ADDR_WIDTH = 8
) (
    input  logic                                     ACLK,
    input  logic                                     ARESET,
    input  logic [C_ADDR_WIDTH-1:0]                  S_AXI_AWADDR,
    input  logic [2:0]                               S_AXI_AWPROT,
    input  logic                                     S_AXI_AWVALID,
    output logic                                     S_AXI_AWREADY,
    input  logic [C_DATA_WIDTH-1:0]                  S_AXI_WDATA,
    input  logic [C_DATA_WIDTH/8-1:0]                S_AXI_WSTRB,
    input  logic                                     S_AXI_WVALID,
    output logic                                     S_AXI_WREADY,
    output logic [1:0]                               S_AXI_BRESP,
    output logic                                     S_AXI_BVALID,
    input  logic                                     S_AXI_BREADY,
    input  logic [C_ADDR_WIDTH-1:0]                  S_AXI_ARADDR,
    input  logic [2:0]                               S_AXI_ARPROT,
    input  logic                                     S_AXI_ARVALID,
    output logic                                     S_AXI_ARREADY,
    output logic [C_DATA_WIDTH-1:0]                  S_AXI_RDATA,
    output logic [1:0]                               S_AXI_RRESP,
    output logic                                     S_AXI_RVALID,
    input  logic                                     S_AXI_RREADY,
    input  logic                                     busy_i,
    input  logic                                     done_i,
    output logic                                     start_o,
    output logic [(C_NUM_REGS-2)*C_DATA_WIDTH-1:0]   regs_o,
    output logic                                     irq_o
);

    localparam int STRB_W   = C_DATA_WIDTH / 8;
    localparam int ADDR_LSB = $clog2(STRB_W);
    localparam int IDX_W    = $clog2(C_NUM_REGS);

    localparam logic [IDX_W-1:0] CTRL_IDX   = IDX_W'(0);
    localparam logic [IDX_W-1:0] STATUS_IDX = IDX_W'(1);
    localparam logic [1:0]       RESP_OKAY   = 2'b00;
    localparam logic [1:0]       RESP_SLVERR = 2'b10;

    function automatic logic addr_oor(input logic [C_ADDR_WIDTH-1:0] addr);
        return (addr >> (IDX_W + ADDR_LSB)) != '0;
    endfunction

    function automatic logic [IDX_W-1:0] addr_idx(input logic [C_ADDR_WIDTH-1:0] addr);
        return IDX_W'(addr >> ADDR_LSB);
    endfunction

    logic                     aw_full;
    logic [C_ADDR_WIDTH-1:0]  aw_addr;
    logic                     w_full;
    logic [C_DATA_WIDTH-1:0]  w_data;
    logic [STRB_W-1:0]        w_strb;

    logic                     aw_hs;
    logic                     w_hs;
    logic                     ar_hs;
    logic                     wr_commit;
    logic [C_ADDR_WIDTH-1:0]  wr_addr;
    logic [C_DATA_WIDTH-1:0]  wr_data;
    logic [STRB_W-1:0]        wr_strb;
    logic                     wr_oor;
    logic [IDX_W-1:0]         wr_idx;
    logic                     rd_oor;
    logic [IDX_W-1:0]         rd_idx;
    logic [C_DATA_WIDTH-1:0]  rd_val;

    // Entries 0 and 1 stay zero; CTRL/STATUS live in dedicated flops below.
    logic [C_DATA_WIDTH-1:0]  regs [C_NUM_REGS];
    logic                     irq_en;
    logic                     done;
    logic                     irq;
    logic                     unused;

    assign S_AXI_AWREADY = !ARESET && !aw_full;
    assign S_AXI_WREADY  = !ARESET && !w_full;
    assign S_AXI_ARREADY = !ARESET && !S_AXI_RVALID;

    assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
    assign w_hs  = S_AXI_WVALID && S_AXI_WREADY;
    assign ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;

    // A channel handshaking this cycle counts as a full buffer, so AW+W together commit immediately.
    assign wr_addr   = aw_full ? aw_addr : S_AXI_AWADDR;
    assign wr_data   = w_full ? w_data : S_AXI_WDATA;
    assign wr_strb   = w_full ? w_strb : S_AXI_WSTRB;
    assign wr_commit = (aw_full || aw_hs) && (w_full || w_hs) && !S_AXI_BVALID;
    assign wr_oor    = addr_oor(wr_addr);
    assign wr_idx    = addr_idx(wr_addr);
    assign rd_oor    = addr_oor(S_AXI_ARADDR);
    assign rd_idx    = addr_idx(S_AXI_ARADDR);

    always_comb begin
        rd_val = '0;
        if (!rd_oor) begin
            if (rd_idx == CTRL_IDX) begin
                rd_val[1] = irq_en;
            end else if (rd_idx == STATUS_IDX) begin
                rd_val[0] = busy_i;
                rd_val[1] = done;
            end else begin
                rd_val = regs[rd_idx];
            end
        end
    end

    // Holding buffers carry data only; their full flags are the control state.
    always_ff @(posedge ACLK) begin
        if (aw_hs) aw_addr <= S_AXI_AWADDR;
        if (w_hs) begin
            w_data <= S_AXI_WDATA;
            w_strb <= S_AXI_WSTRB;
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            aw_full      <= 1'b0;
            w_full       <= 1'b0;
            S_AXI_BVALID <= 1'b0;
            S_AXI_BRESP  <= RESP_OKAY;
            S_AXI_RVALID <= 1'b0;
            S_AXI_RRESP  <= RESP_OKAY;
            S_AXI_RDATA  <= '0;
            start_o      <= 1'b0;
            for (int r = 0; r < C_NUM_REGS; r++) regs[r] <= '0;
        end else begin
            aw_full <= (aw_full || aw_hs) && !wr_commit;
            w_full  <= (w_full || w_hs) && !wr_commit;
            start_o <= 1'b0;

            if (wr_commit) begin
                S_AXI_BVALID <= 1'b1;
                S_AXI_BRESP  <= wr_oor ? RESP_SLVERR : RESP_OKAY;
            end else if (S_AXI_BREADY) begin
                S_AXI_BVALID <= 1'b0;
            end

            if (wr_commit && !wr_oor) begin
                if (wr_idx == CTRL_IDX) begin
                    if (wr_strb[0]) start_o <= wr_data[0];
                end else if (wr_idx != STATUS_IDX) begin
                    for (int b = 0; b < STRB_W; b++) begin
                        if (wr_strb[b]) regs[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
                    end
                end
            end

            // rd_val is sampled before this edge's write lands, giving read-before-write.
            if (ar_hs) begin
                S_AXI_RVALID <= 1'b1;
                S_AXI_RDATA  <= rd_val;
                S_AXI_RRESP  <= rd_oor ? RESP_SLVERR : RESP_OKAY;
            end else if (S_AXI_RREADY) begin
                S_AXI_RVALID <= 1'b0;
            end
        end
    end

`ifdef NPU_CTRL_REGS_IRQ_EN
    logic ctrl_wr;
    logic done_clr;

    assign ctrl_wr  = wr_commit && !wr_oor && wr_idx == CTRL_IDX && wr_strb[0];
    assign done_clr = wr_commit && !wr_oor && wr_idx == STATUS_IDX && wr_strb[0] && wr_data[1];

    // A done_i pulse wins over a simultaneous write-1-to-clear.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            irq_en <= 1'b0;
            done   <= 1'b0;
            irq    <= 1'b0;
        end else begin
            if (ctrl_wr) irq_en <= wr_data[1];
            if (done_i) done <= 1'b1;
            else if (done_clr) done <= 1'b0;
            irq <= done && irq_en;
        end
    end

    assign unused = &{1'b0, S_AXI_AWPROT, S_AXI_ARPROT};
`else
    assign irq_en = 1'b0;
    assign done   = 1'b0;
    assign irq    = 1'b0;
    assign unused = &{1'b0, S_AXI_AWPROT, S_AXI_ARPROT, done_i};
`endif

    assign irq_o = irq;

    for (genvar r = 2; r < C_NUM_REGS; r++) begin : g_flat
        assign regs_o[(r-2)*C_DATA_WIDTH +: C_DATA_WIDTH] = regs[r];
    end

endmodule

// File: tb/tb_npu_ctrl_regs.sv
// Scoreboard bench for npu_ctrl_regs: tasks push expected responses, negedge monitors pop and compare.
`timescale 1ns/1ps
module tb_npu_ctrl_regs;

    localparam int DW = 32;
    localparam int NR = 16;
    localparam int AW = 8;
`ifdef NPU_CTRL_REGS_IRQ_EN
    localparam bit HAS_IRQ = 1'b1;
`else
    localparam bit HAS_IRQ = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              ARESET = 1'b1;
    logic [AW-1:0]     S_AXI_AWADDR = '0;
    logic [2:0]        S_AXI_AWPROT = '0;
    logic              S_AXI_AWVALID = 1'b0;
    logic              S_AXI_AWREADY;
    logic [DW-1:0]     S_AXI_WDATA = '0;
    logic [DW/8-1:0]   S_AXI_WSTRB = '0;
    logic              S_AXI_WVALID = 1'b0;
    logic              S_AXI_WREADY;
    logic [1:0]        S_AXI_BRESP;
    logic              S_AXI_BVALID;
    logic              S_AXI_BREADY = 1'b0;
    logic [AW-1:0]     S_AXI_ARADDR = '0;
    logic [2:0]        S_AXI_ARPROT = '0;
    logic              S_AXI_ARVALID = 1'b0;
    logic              S_AXI_ARREADY;
    logic [DW-1:0]     S_AXI_RDATA;
    logic [1:0]        S_AXI_RRESP;
    logic              S_AXI_RVALID;
    logic              S_AXI_RREADY = 1'b0;
    logic              busy_i = 1'b0;
    logic              done_i = 1'b0;
    logic              start_o;
    logic [(NR-2)*DW-1:0] regs_o;
    logic              irq_o;

    always #5 clk = ~clk;

    npu_ctrl_regs #(.C_DATA_WIDTH(DW), .C_NUM_REGS(NR), .C_ADDR_WIDTH(AW)) dut (
        .ACLK(clk), .ARESET(ARESET),
        .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
        .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
        .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
        .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
        .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
        .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
        .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
        .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
        .busy_i(busy_i), .done_i(done_i), .start_o(start_o),
        .regs_o(regs_o), .irq_o(irq_o)
    );

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } rd_exp_t;

    int tests = 0;
    int fails = 0;
    logic [1:0] b_q[$];
    rd_exp_t    r_q[$];

    // Reference model: register contents as the software view defines them.
    logic [31:0] m_regs [NR];
    bit          m_irq_en;
    bit          m_done;
    int          exp_starts = 0;
    int          seen_starts = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        tests++;
        fails++;
        $display("FAIL %s: timed out waiting for the DUT", name);
    endtask

    always @(negedge clk) begin
        if (!ARESET && S_AXI_BVALID && S_AXI_BREADY) begin
            if (b_q.size() == 0) timeout_fail("bresp_unexpected");
            else check("bresp", S_AXI_BRESP, b_q.pop_front());
        end
        if (!ARESET && S_AXI_RVALID && S_AXI_RREADY) begin
            rd_exp_t e;
            if (r_q.size() == 0) begin
                timeout_fail("rresp_unexpected");
            end else begin
                e = r_q.pop_front();
                check("rdata", S_AXI_RDATA, e.data);
                check("rresp", S_AXI_RRESP, e.resp);
            end
        end
        if (start_o) seen_starts++;
    end

    function automatic void model_reset();
        for (int r = 0; r < NR; r++) m_regs[r] = '0;
        m_irq_en = 1'b0;
        m_done   = 1'b0;
    endfunction

    function automatic void model_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
        int ai = int'(a);
        int idx = ai / 4;
        if (ai >= NR * 4) begin
            b_q.push_back(2'b10);
            return;
        end
        b_q.push_back(2'b00);
        if (idx == 0) begin
            if (s[0] && d[0]) exp_starts++;
            if (s[0]) m_irq_en = HAS_IRQ && d[1];
        end else if (idx == 1) begin
            if (s[0] && d[1]) m_done = 1'b0;
        end else begin
            for (int b = 0; b < 4; b++) if (s[b]) m_regs[idx][8*b +: 8] = d[8*b +: 8];
        end
    endfunction

    function automatic rd_exp_t model_read(input logic [7:0] a);
        rd_exp_t e;
        int ai = int'(a);
        int idx = ai / 4;
        e.resp = 2'b00;
        e.data = '0;
        if (ai >= NR * 4) e.resp = 2'b10;
        else if (idx == 0) e.data = {30'd0, m_irq_en, 1'b0};
        else if (idx == 1) e.data = {30'd0, m_done, busy_i};
        else e.data = m_regs[idx];
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                               input int aw_dly, input int w_dly);
        bit aw_pend = 1'b1;
        bit w_pend = 1'b1;
        bit aw_hs, w_hs;
        int t = 0;
        S_AXI_AWADDR = a;
        S_AXI_WDATA  = d;
        S_AXI_WSTRB  = s;
        while ((aw_pend || w_pend) && t < 64) begin
            S_AXI_AWVALID = aw_pend && t >= aw_dly;
            S_AXI_WVALID  = w_pend && t >= w_dly;
            @(negedge clk);
            aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
            w_hs  = S_AXI_WVALID && S_AXI_WREADY;
            step();
            if (aw_hs) aw_pend = 1'b0;
            if (w_hs) w_pend = 1'b0;
            t++;
        end
        S_AXI_AWVALID = 1'b0;
        S_AXI_WVALID  = 1'b0;
        if (aw_pend || w_pend) timeout_fail("write_handshake");
    endtask

    task automatic wait_b(input int hold);
        int t = 0;
        while (!S_AXI_BVALID && t < 32) begin
            step();
            t++;
        end
        if (!S_AXI_BVALID) begin
            timeout_fail("bvalid");
            return;
        end
        repeat (hold) step();
        S_AXI_BREADY = 1'b1;
        step();
        S_AXI_BREADY = 1'b0;
    endtask

    task automatic drive_ar(input logic [7:0] a, input int dly);
        bit pend = 1'b1;
        bit hs;
        int t = 0;
        S_AXI_ARADDR = a;
        while (pend && t < 64) begin
            S_AXI_ARVALID = t >= dly;
            @(negedge clk);
            hs = S_AXI_ARVALID && S_AXI_ARREADY;
            step();
            if (hs) pend = 1'b0;
            t++;
        end
        S_AXI_ARVALID = 1'b0;
        if (pend) timeout_fail("read_handshake");
    endtask

    task automatic wait_r(input int hold);
        int t = 0;
        while (!S_AXI_RVALID && t < 32) begin
            step();
            t++;
        end
        if (!S_AXI_RVALID) begin
            timeout_fail("rvalid");
            return;
        end
        repeat (hold) step();
        S_AXI_RREADY = 1'b1;
        step();
        S_AXI_RREADY = 1'b0;
    endtask

    task automatic do_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
        model_write(a, d, s);
        drive_write(a, d, s, $urandom_range(0, 3), $urandom_range(0, 3));
        wait_b($urandom_range(0, 2));
    endtask

    task automatic do_read(input logic [7:0] a);
        r_q.push_back(model_read(a));
        drive_ar(a, $urandom_range(0, 2));
        wait_r($urandom_range(0, 2));
    endtask

    task automatic check_regs();
        for (int r = 2; r < NR; r++) check("regs_o", regs_o[(r-2)*DW +: DW], m_regs[r]);
    endtask

    task automatic pulse_done();
        done_i = 1'b1;
        step();
        done_i = 1'b0;
        m_done = m_done || HAS_IRQ;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int starts_before;
        logic [7:0] a;
        model_reset();

        // Reset state
        repeat (3) step();
        check("awready_rst", S_AXI_AWREADY, 0);
        check("wready_rst", S_AXI_WREADY, 0);
        check("arready_rst", S_AXI_ARREADY, 0);
        check("bvalid_rst", S_AXI_BVALID, 0);
        check("rvalid_rst", S_AXI_RVALID, 0);
        check("start_rst", start_o, 0);
        check("irq_rst", irq_o, 0);
        check_regs();
        ARESET = 1'b0;
        #1;
        check("awready_up", S_AXI_AWREADY, 1);
        check("wready_up", S_AXI_WREADY, 1);
        check("arready_up", S_AXI_ARREADY, 1);
        step();

        // Basic write/read-back of the general registers
        do_write(8'h08, 32'h1, 4'hF);
        do_write(8'h0C, 32'h2, 4'hF);
        do_write(8'h10, 32'h3, 4'hF);
        do_write(8'h14, 32'h4, 4'hF);
        for (int i = 0; i < 4; i++) do_read(8'(8 + 4 * i));
        check("regs_o_reg2", regs_o[31:0], 32'h1);
        check_regs();

        // Byte-strobe merge
        do_write(8'h08, 32'h11223344, 4'hF);
        do_write(8'h08, 32'hAABBCCDD, 4'b0101);
        do_read(8'h08);
        check("strobe_merge", regs_o[31:0], 32'h11BB33DD);

        // AW ahead of W, then held BREADY with a second write parked in the buffers
        model_write(8'h18, 32'hCAFE0001, 4'hF);
        drive_write(8'h18, 32'hCAFE0001, 4'hF, 0, 2);
        check("bvalid_first", S_AXI_BVALID, 1);
        S_AXI_AWADDR = 8'h1C;
        S_AXI_WDATA = 32'h55;
        S_AXI_WSTRB = 4'hF;
        S_AXI_AWVALID = 1'b1;
        S_AXI_WVALID = 1'b1;
        @(negedge clk);
        check("aw_accept_pending", S_AXI_AWREADY && S_AXI_WREADY, 1);
        step();
        S_AXI_AWVALID = 1'b0;
        S_AXI_WVALID = 1'b0;
        check("aw_buffer_full", S_AXI_AWREADY, 0);
        do_read(8'h1C);
        model_write(8'h1C, 32'h55, 4'hF);
        for (int i = 0; i < 3; i++) begin
            check("bvalid_hold", S_AXI_BVALID, 1);
            step();
        end
        check("no_commit_while_bvalid", regs_o[5*DW +: DW], 32'h0);
        S_AXI_BREADY = 1'b1;
        step();
        S_AXI_BREADY = 1'b0;
        wait_b(0);
        check("second_write", regs_o[5*DW +: DW], 32'h55);

        // START doorbell and IRQ_EN
        starts_before = seen_starts;
        do_write(8'h00, 32'h3, 4'hF);
        check("start_one_cycle", seen_starts - starts_before, 1);
        do_read(8'h00);

        // DONE / irq timing
        pulse_done();
        check("irq_n1", irq_o, 0);
        step();
        check("irq_n2", irq_o, m_done && m_irq_en);
        busy_i = 1'b1;
        do_read(8'h04);
        busy_i = 1'b0;

        // W1C in the same cycle as done_i: set wins
        model_write(8'h04, 32'h2, 4'hF);
        m_done = m_done || HAS_IRQ;
        S_AXI_AWADDR = 8'h04;
        S_AXI_WDATA = 32'h2;
        S_AXI_WSTRB = 4'hF;
        S_AXI_AWVALID = 1'b1;
        S_AXI_WVALID = 1'b1;
        done_i = 1'b1;
        step();
        S_AXI_AWVALID = 1'b0;
        S_AXI_WVALID = 1'b0;
        done_i = 1'b0;
        wait_b(0);
        do_read(8'h04);
        check("irq_after_race", irq_o, m_done && m_irq_en);
        do_write(8'h04, 32'h2, 4'hF);
        check("irq_cleared", irq_o, 0);
        do_read(8'h04);

        // Out-of-range accesses
        do_write(8'h40, 32'hFFFFFFFF, 4'hF);
        do_read(8'h40);
        do_write(8'hC8, 32'h12345678, 4'hF);
        do_read(8'hFC);
        check_regs();

        // Randomized traffic against the model
        for (int i = 0; i < 200; i++) begin
            a = ($urandom_range(0, 3) != 0) ? 8'($urandom_range(0, 63)) : 8'($urandom_range(0, 255));
            busy_i = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) begin
                pulse_done();
                step();
            end
            if ($urandom_range(0, 1) == 0) do_write(a, $urandom, 4'($urandom_range(0, 15)));
            else do_read(a);
            check("irq_rand", irq_o, m_done && m_irq_en);
            if (i % 50 == 49) check_regs();
        end
        busy_i = 1'b0;

        // Reset while a read response is pending
        S_AXI_ARADDR = 8'h08;
        drive_ar(8'h08, 0);
        check("rvalid_pending", S_AXI_RVALID, 1);
        ARESET = 1'b1;
        step();
        check("rvalid_after_reset", S_AXI_RVALID, 0);
        check("bvalid_after_reset", S_AXI_BVALID, 0);
        check("irq_after_reset", irq_o, 0);
        model_reset();
        ARESET = 1'b0;
        step();
        check_regs();
        do_read(8'h08);
        do_read(8'h00);
        repeat (4) step();

        check("start_count", seen_starts, exp_starts);
        check("b_queue_drained", b_q.size(), 0);
        check("r_queue_drained", r_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/npu_ctrl_regs.md
# npu_ctrl_regs

Parametrised AXI4-Lite control/status register slave for the RISC-V/NPU subsystem, replacing the fixed four-register control IP. Provides a configurable number of byte-strobed read/write registers, a self-clearing START doorbell, a sticky write-1-to-clear DONE flag with interrupt, and SLVERR on out-of-range accesses. It sits between the PS/RISC-V AXI interconnect and the NPU core control inputs.

## Interface
- C_DATA_WIDTH, 32: AXI data width; 32 or 64.
- C_NUM_REGS, 16: total registers, power of 2, 4..256.
- C_ADDR_WIDTH, 8: AXI byte-address width; must be at least log2(C_NUM_REGS) + log2(C_DATA_WIDTH/8).

Ports:
- ACLK  in  1  clock.
- ARESET  in  1  reset, synchronous, active-high.
- S_AXI_AWADDR/AWPROT/AWVALID/AWREADY  in/in/in/out  C_ADDR_WIDTH/3/1/1  write address channel; AWPROT ignored.
- S_AXI_WDATA/WSTRB/WVALID/WREADY  in/in/in/out  C_DATA_WIDTH/C_DATA_WIDTH/8/1/1  write data channel.
- S_AXI_BRESP/BVALID/BREADY  out/out/in  2/1/1  write response channel.
- S_AXI_ARADDR/ARPROT/ARVALID/ARREADY  in/in/in/out  C_ADDR_WIDTH/3/1/1  read address channel; ARPROT ignored.
- S_AXI_RDATA/RRESP/RVALID/RREADY  out/out/out/in  C_DATA_WIDTH/2/1/1  read data channel.
- busy_i  in  1  NPU busy; read through STATUS bit 0.
- done_i  in  1  NPU completion pulse; sets DONE.
- start_o  out  1  one-cycle start pulse to NPU.
- regs_o  out  (C_NUM_REGS-2)*C_DATA_WIDTH  flattened general registers 2..N-1; reg 2 in the LSBs.
- irq_o  out  1  level interrupt.

## Operation
- Register index = addr[log2(C_NUM_REGS)+log2(C_DATA_WIDTH/8)-1 : log2(C_DATA_WIDTH/8)]. Low address bits are ignored.
- Any upper address bit set (index at or above C_NUM_REGS) makes the access out of range.
  - Out-of-range write: dropped, BRESP=2'b10.
  - Out-of-range read: RDATA=0, RRESP=2'b10.
  - In-range accesses return 2'b00.
- Reg 0 CTRL:
  - bit 0 START: writing 1 pulses start_o; the bit always reads 0.
  - bit 1 IRQ_EN: read/write.
  - Other bits read 0.
- Reg 1 STATUS:
  - bit 0 BUSY: read-only, mirrors busy_i.
  - bit 1 DONE: sticky, write-1-to-clear.
  - Other bits read 0; writes to them are ignored.
- Regs 2..N-1: full read/write, masked by WSTRB per byte lane.
  - CTRL and STATUS writes take effect only if WSTRB[0] is set.
- AW and W are captured independently into one-entry holding buffers, in either order.
- The write commits in the cycle both buffers are full and BVALID is low. The buffers free on commit.
- One outstanding write and one outstanding read at most.
- A read and a write committing in the same cycle to the same register: the read returns the pre-write value.
- DONE: set by done_i, cleared by a W1C write. A simultaneous set and clear leaves DONE=1.
- irq_o = registered DONE & IRQ_EN.

## Timing
- During and after reset: all registers 0; all READY, BVALID, RVALID, start_o and irq_o are 0.
- AWREADY/WREADY/ARREADY rise in the first cycle after ARESET deasserts.
- AWREADY = AW buffer empty. WREADY = W buffer empty. ARREADY = !RVALID.
- AW and W handshakes both in cycle N: register updated at the end of N; BVALID=1 from N+1.
- BVALID holds until BREADY. While BVALID is high, further AW/W are buffered but not committed.
- start_o is high for exactly cycle N+1 after a START commit in cycle N.
- AR handshake in cycle N: RVALID and RDATA valid from N+1. They hold stable until RREADY; ARREADY is low meanwhile.
- done_i high in cycle N: DONE=1 readable from N+1; irq_o=1 from N+2 if IRQ_EN.
- ARESET asserted mid-transaction: buffers and pending responses are discarded; VALIDs are 0 the next cycle; no response is issued for the aborted access.

## Configuration
- NPU_CTRL_REGS_IRQ_EN defined: DONE flag, IRQ_EN bit and irq_o logic are present as described.
- Not defined:
  - DONE and IRQ_EN read 0; writes to them are ignored.
  - done_i is unused; irq_o is tied to 0.
  - All other behaviour is unchanged.

## Test plan
- Write 0x1, 0x2, 0x3, 0x4 to addr 0x08, 0x0C, 0x10, 0x14, then read back -> data matches, all responses OKAY, regs_o reg 2 = 0x1.
- Write 0xAABBCCDD to addr 0x08 with WSTRB=4'b0101 over prior 0x11223344 -> reads 0x11BB33DD.
- AW two cycles before W; then BREADY held low 5 cycles -> single BVALID, stays high until BREADY, a second write is not committed meanwhile.
- Write 0x3 to CTRL -> start_o high exactly one cycle, CTRL reads 0x2.
- With NPU_CTRL_REGS_IRQ_EN: pulse done_i -> STATUS reads 0x2, irq_o=1. Write 0x2 to STATUS in the same cycle as a done_i pulse -> DONE stays 1. Write 0x2 alone -> irq_o=0.
- Access addr 0x40 with C_NUM_REGS=16 -> BRESP/RRESP=2'b10, RDATA=0, no register changes. Assert ARESET with RVALID high -> RVALID=0 next cycle.
